ten_bit_serializer: RTL
=======================

// Module: ten_bit_serializer
// PURPOSE
//  Parallel-in/serial-out stage directly downstream of the 8b/10b encoder.
//  - Accepts one 10-bit encoded symbol per valid/ready handshake.
//  - Shifts it out one bit per i_CLK, bit 9 ('a') first.
//  - On underrun (no symbol ready at a symbol boundary), sends IDLE_SYMBOL and flags the event.
// PARAMETERS
//  SYMBOL_W     10             symbol width; only 10 is supported
//  IDLE_SYMBOL  10'b0011111010 fill symbol {abcdei,fghj}; K28.5, RD- form
// PORTS
//  i_CLK          in   1   sole clock; all state changes on rising edge
//  i_RST_N        in   1   synchronous, active-low reset
//  i_SYMBOL       in   10  encoded symbol {abcdei,fghj}; bit 9 = 'a'
//  i_VALID        in   1   i_SYMBOL valid
//  o_READY        out  1   serializer can take i_SYMBOL this cycle
//  o_SERIAL       out  1   serial line bit (registered)
//  o_SYMBOL_START out  1   high while o_SERIAL carries bit 9 of a symbol
//  o_IDLE         out  1   high while the symbol on the line is an inserted IDLE_SYMBOL
//  o_UNDERRUN     out  1   1-cycle pulse when IDLE_SYMBOL is loaded because HOLD is empty
// BEHAVIOUR
//  State: SHIFT[9:0], CNT[3:0] (0..9), HOLD[9:0], HOLD_V, IDLE_F.
//   o_SERIAL = SHIFT[9]. o_SYMBOL_START = (CNT==0). o_IDLE = IDLE_F.
//  Reset (i_RST_N==0 at edge):
//   SHIFT<=IDLE_SYMBOL, CNT<=0, HOLD_V<=0, IDLE_F<=1, o_UNDERRUN<=0.
//   Outputs during/after reset: o_SERIAL=0, o_SYMBOL_START=1, o_IDLE=1, o_UNDERRUN=0.
//   o_READY is forced 0 while i_RST_N is low.
//   Reset mid-symbol discards the partial symbol and HOLD; no underrun pulse is raised for it.
//  Handshake:
//   o_READY = i_RST_N & (~HOLD_V | (CNT==9)); combinational, no dependence on i_VALID.
//   A transfer occurs when i_VALID & o_READY.
//   i_SYMBOL is sampled only on a transfer; it may change freely otherwise.
//  Shift (CNT!=9): SHIFT<={SHIFT[8:0],1'b0}; CNT<=CNT+1. A transfer sets HOLD<=i_SYMBOL, HOLD_V<=1.
//  Boundary (CNT==9): CNT<=0; SHIFT loads the next symbol, by priority:
//   1. HOLD_V=1: SHIFT<=HOLD, IDLE_F<=0. HOLD_V<=transfer, HOLD<=i_SYMBOL if transfer.
//   2. HOLD_V=0 and transfer this cycle: bypass, SHIFT<=i_SYMBOL, IDLE_F<=0, HOLD_V stays 0.
//   3. Otherwise: SHIFT<=IDLE_SYMBOL, IDLE_F<=1, o_UNDERRUN<=1 for one cycle.
//  o_UNDERRUN is 0 on all other cycles.
//  Latency:
//   Bypass path: transfer at CNT==9 -> bit 9 on o_SERIAL next cycle.
//   Held symbol: starts on the first boundary after its transfer.
//  Throughput: 1 symbol per 10 cycles, back-to-back with no gap when the source keeps i_VALID high.
//  Held symbol is never overwritten: o_READY=0 while HOLD_V=1 and CNT!=9.
//  Running disparity: IDLE_SYMBOL is inserted without encoder feedback, so the line RD is not
//   guaranteed across an underrun. o_UNDERRUN is a link-error indication; upstream owns idle
//   generation in normal operation.
// STRUCTURE
//  - Shared package eight_ten_pkg:
//    constants SYMBOL_W=10, K28_5_RDN=10'b0011111010, K28_5_RDP=10'b1100000101.
//    Same package serves the encoder and the future decoder/deserializer.
//  - Single module, no sub-modules: the shift register, counter and 1-entry hold buffer are all inline.
// TESTING
//  1. Reset, hold i_VALID=0 for 30 cycles:
//     o_SERIAL repeats 0011111010 with o_IDLE=1.
//     o_UNDERRUN pulses at cycles 10 and 20 after reset release.
//  2. Single symbol 10'b1010011100 presented at CNT==9 with HOLD empty:
//     bypass; o_SERIAL=1,0,1,0,0,1,1,1,0,0 starting the next cycle.
//     o_SYMBOL_START on the first of those bits, o_IDLE=0.
//  3. Back-to-back 10'h2AA, 10'h155, 10'h3F0 with i_VALID held high:
//     30 contiguous bits with no idle between symbols, o_UNDERRUN never asserts.
//     o_READY low for 9 of every 10 cycles once HOLD fills.
//  4. Backpressure: HOLD full and CNT=4, i_VALID=1:
//     o_READY=0, HOLD unchanged, i_SYMBOL changes ignored until CNT==9.
//  5. Reset asserted at CNT=5 mid-symbol with HOLD full:
//     next cycle o_SERIAL=0, o_SYMBOL_START=1, o_IDLE=1, HOLD dropped.
//     The first boundary after reset loads IDLE with o_UNDERRUN=1.
//  6. Random symbols with random i_VALID gaps, against a scoreboard:
//     every accepted symbol appears exactly once, in order, MSB first.
//     Gaps are filled only by IDLE_SYMBOL, each flagged by one o_UNDERRUN pulse.

Source files
------------

// File: rtl/eight_ten_pkg.sv
// Shared 8b/10b constants used by the encoder, serializer and the future decoder path.
package eight_ten_pkg;

    localparam int unsigned SYMBOL_W = 10;

    // K28.5 comma in both running-disparity forms, {abcdei,fghj}
    localparam logic [SYMBOL_W-1:0] K28_5_RDN = 10'b0011111010;
    localparam logic [SYMBOL_W-1:0] K28_5_RDP = 10'b1100000101;

endpackage

// File: rtl/ten_bit_serializer.sv
// Parallel-in/serial-out stage for 8b/10b symbols: bit 9 first, one-entry hold buffer,
// and IDLE_SYMBOL fill with an underrun flag when no symbol is available at a boundary.
module ten_bit_serializer #(
    parameter int unsigned          SYMBOL_W    = eight_ten_pkg::SYMBOL_W,
    parameter logic [SYMBOL_W-1:0]  IDLE_SYMBOL = eight_ten_pkg::K28_5_RDN
) (
    input  logic                i_CLK,
    input  logic                i_RST_N,
    input  logic [SYMBOL_W-1:0] i_SYMBOL,
    input  logic                i_VALID,
    output logic                o_READY,
    output logic                o_SERIAL,
    output logic                o_SYMBOL_START,
    output logic                o_IDLE,
    output logic                o_UNDERRUN
);

    localparam logic [3:0] CntLast = 4'(SYMBOL_W - 1);

    logic [SYMBOL_W-1:0] shift_q, shift_d;
    logic [SYMBOL_W-1:0] hold_q, hold_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                hold_v_q, hold_v_d;
    logic                idle_q, idle_d;
    logic                underrun_q, underrun_d;
    logic                at_boundary;
    logic                xfer;

    assign at_boundary = (cnt_q == CntLast);
    // The hold slot only frees up at a boundary, so a held symbol is never overwritten.
    assign o_READY     = i_RST_N & (~hold_v_q | at_boundary);
    assign xfer        = i_VALID & o_READY;

    always_comb begin
        shift_d    = shift_q;
        hold_d     = hold_q;
        cnt_d      = cnt_q;
        hold_v_d   = hold_v_q;
        idle_d     = idle_q;
        underrun_d = 1'b0;

        if (at_boundary) begin
            cnt_d = 4'd0;
            if (hold_v_q) begin
                shift_d  = hold_q;
                idle_d   = 1'b0;
                hold_v_d = xfer;
                if (xfer) begin
                    hold_d = i_SYMBOL;
                end
            end else if (xfer) begin
                // Bypass the hold slot so a symbol arriving on time costs no extra latency
                shift_d = i_SYMBOL;
                idle_d  = 1'b0;
            end else begin
                shift_d    = IDLE_SYMBOL;
                idle_d     = 1'b1;
                underrun_d = 1'b1;
            end
        end else begin
            shift_d = {shift_q[SYMBOL_W-2:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
            if (xfer) begin
                hold_d   = i_SYMBOL;
                hold_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            shift_q    <= IDLE_SYMBOL;
            hold_q     <= '0;
            cnt_q      <= 4'd0;
            hold_v_q   <= 1'b0;
            idle_q     <= 1'b1;
            underrun_q <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            hold_v_q   <= hold_v_d;
            idle_q     <= idle_d;
            underrun_q <= underrun_d;
        end
    end

    assign o_SERIAL       = shift_q[SYMBOL_W-1];
    assign o_SYMBOL_START = (cnt_q == 4'd0);
    assign o_IDLE         = idle_q;
    assign o_UNDERRUN     = underrun_q;

endmodule
